// File: rtl/decoder_pkg.sv
// Shared decoder types: machine word, ALU and divider operation encodings,
// and the divider step count.
package decoder_pkg;

  typedef logic [31:0] word;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    DIV_DIV,
    DIV_DIVU,
    DIV_REM,
    DIV_REMU
  } div_op_t;

  localparam int DIV_STEPS = 32;

  // DIV and REM interpret their operands as two's complement.
  function automatic logic div_op_signed(input div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic div_op_is_rem(input div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// The partial remainder is always below the divisor, so a 33-bit trial
// subtraction covers the shifted value and the result fits back in a word.
module div_step
  import decoder_pkg::*;
(
  input  word  rem,
  input  word  divisor,
  input  logic dividend_bit,
  output word  rem_next,
  output logic q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Shift in the next dividend bit, try the subtraction, restore on borrow.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider (DIV, DIVU, REM, REMU): one restoring step per
// cycle on operand magnitudes, sign correction when the result is registered.
// Divide-by-zero and signed overflow are detected at capture and produce a
// forced result.
// Optional macro DIV_FAST_SPECIAL_EN: special cases bypass the step phase
// and complete one cycle after capture.
module div_unit
  import decoder_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  div_op_t op,
  input  word     a,
  input  word     b,
  output logic    busy,
  output logic    done,
  output word     res
);

  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  word              rem_q;
  word              quo_q;
  word              dsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             is_rem_q;
  logic             special_q;
  word              special_res_q;

  // Magnitude of an operand; unsigned ops pass through untouched.
  function automatic word mag_of(input word v, input logic is_signed);
    logic signed [31:0] sv;
    sv = $signed(v);
    return (is_signed && sv[31]) ? word'(-sv) : v;
  endfunction

  // Apply the result sign to an unsigned magnitude.
  function automatic word apply_sign(input word mag, input logic neg);
    logic signed [31:0] sm;
    sm = $signed(mag);
    return neg ? word'(-sm) : mag;
  endfunction

  logic op_signed;
  logic op_rem;
  logic div_by_zero;
  logic sgn_overflow;
  logic special_det;
  word  special_val;

  // Classify the operands presented with start.
  always_comb begin
    op_signed    = div_op_signed(op);
    op_rem       = div_op_is_rem(op);
    div_by_zero  = (b == 32'h0);
    sgn_overflow = op_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special_det  = div_by_zero || sgn_overflow;
    special_val  = 32'h0;
    if (div_by_zero) begin
      special_val = op_rem ? a : 32'hFFFF_FFFF;
    end else if (sgn_overflow) begin
      special_val = op_rem ? 32'h0 : 32'h8000_0000;
    end
  end

  word  rem_nx;
  logic q_bit;
  word  quo_nx;
  word  final_res;

  div_step u_step (
    .rem          (rem_q),
    .divisor      (dsr_q),
    .dividend_bit (quo_q[31]),
    .rem_next     (rem_nx),
    .q_bit        (q_bit)
  );

  // Quotient bits shift in from the bottom as dividend bits leave the top;
  // on the last step this is the full quotient magnitude.
  always_comb begin
    quo_nx = {quo_q[30:0], q_bit};
    if (special_q) begin
      final_res = special_res_q;
    end else if (is_rem_q) begin
      final_res = apply_sign(rem_nx, neg_rem_q);
    end else begin
      final_res = apply_sign(quo_nx, neg_quo_q);
    end
  end

  // Control FSM with registered busy/done/res and the step datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dsr_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      is_rem_q      <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      res           <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            cnt           <= '0;
            rem_q         <= '0;
            quo_q         <= mag_of(a, op_signed);
            dsr_q         <= mag_of(b, op_signed);
            neg_quo_q     <= op_signed && (a[31] ^ b[31]);
            neg_rem_q     <= op_signed && a[31];
            is_rem_q      <= op_rem;
            special_q     <= special_det;
            special_res_q <= special_val;
`ifdef DIV_FAST_SPECIAL_EN
            if (special_det) begin
              state <= S_DONE;
              done  <= 1'b1;
              res   <= special_val;
            end else begin
              state <= S_CALC;
              busy  <= 1'b1;
            end
`else
            state <= S_CALC;
            busy  <= 1'b1;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            res   <= final_res;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_unit;
  import decoder_pkg::*;

  logic    clk;
  logic    reset;
  logic    start;
  div_op_t op;
  word     a;
  word     b;
  logic    busy;
  logic    done;
  word     res;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 32;
`endif
  localparam int NORMAL_LAT = 32;

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input word got, input word exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input div_op_t o, input word x, input word y);
    bit sgn;
    sgn = (o == DIV_DIV) || (o == DIV_REM);
    return (y == 0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Reference: RISC-V style division semantics using native arithmetic.
  function automatic word model(input div_op_t o, input word x, input word y);
    int signed sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      DIV_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_REMU: return (y == 0) ? x : x % y;
      DIV_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return word'(sx / sy);
      end
      default: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return word'(sx % sy);
      end
    endcase
  endfunction

  // Present an operation for one edge, then scramble the inputs.
  task automatic launch(input div_op_t o, input word x, input word y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = div_op_t'($urandom_range(0, 3));
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int pre, output word r, output int lat,
                           output bit busy_ok);
    int edges;
    edges   = pre;
    busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (edges > 100) break;
      @(posedge clk);
      edges++;
    end
    lat = edges;
    r   = res;
  endtask

  task automatic run_check(input string tag, input div_op_t o, input word x,
                           input word y);
    word r;
    int  lat;
    bit  bok;
    launch(o, x, y);
    wait_done(0, r, lat, bok);
    chk({tag, "_res"}, r, model(o, x, y));
    chk({tag, "_lat"}, word'(lat),
        word'(is_special(o, x, y) ? SPECIAL_LAT : NORMAL_LAT));
    chk({tag, "_busy_calc"}, word'(bok), 32'd1);
    chk({tag, "_busy_done"}, word'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, word'(done), 32'd0);
  endtask

  initial begin
    word r;
    int  lat;
    bit  bok;
    int  seen;

    reset = 1'b0; start = 1'b0; op = DIV_DIVU; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", word'(busy), 32'd0);
    chk("rst_done", word'(done), 32'd0);
    chk("rst_res", res, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_check("divu_100_7", DIV_DIVU, 32'd100, 32'd7);
    run_check("remu_100_7", DIV_REMU, 32'd100, 32'd7);
    run_check("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2);
    run_check("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2);
    run_check("div_by0", DIV_DIV, 32'd5, 32'd0);
    run_check("remu_by0", DIV_REMU, 32'd5, 32'd0);
    run_check("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_max", DIV_DIVU, 32'hFFFF_FFFF, 32'd1);

    // start during CALC must not disturb the running operation
    launch(DIV_DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = DIV_DIV; a = 32'd5; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, r, lat, bok);
    chk("ign_start_res", r, 32'd333);
    chk("ign_start_lat", word'(lat), word'(NORMAL_LAT));

    // back-to-back accept in the DONE cycle
    @(negedge clk);
    launch(DIV_DIVU, 32'd100, 32'd7);
    wait_done(0, r, lat, bok);
    chk("b2b_first_res", r, 32'd14);
    op = DIV_REMU; a = 32'd9; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, r, lat, bok);
    chk("b2b_second_res", r, 32'd1);
    chk("b2b_second_lat", word'(lat), word'(NORMAL_LAT));

    // reset in the middle of CALC aborts with no done pulse
    @(negedge clk);
    launch(DIV_DIV, 32'hFFFF_FC18, 32'd7);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_busy", word'(busy), 32'd0);
    chk("midrst_done", word'(done), 32'd0);
    chk("midrst_res", res, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", word'(seen), 32'd0);
    run_check("post_rst", DIV_DIV, 32'hFFFF_FC18, 32'd7);

    // randomized operands with a bias toward the boundary cases
    for (int i = 0; i < 30; i++) begin
      div_op_t ro;
      word     ra, rb;
      int      sel;
      ro  = div_op_t'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel <= 4) rb = word'($urandom_range(1, 20));
      else if (sel == 5) rb = -word'($urandom_range(1, 20));
      run_check("rand", ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; operand and result width are fixed by type word (32 bits).
REQ-002 clk  input  1  core clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only when idle or done.
REQ-005 op  input  div_op_t  one of DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU.
REQ-006 a  input  word  dividend.
REQ-007 b  input  word  divisor.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse when res is valid.
REQ-010 res  output  word  quotient or remainder per op; held until the next accepted start.

Function
REQ-011 FSM states: IDLE, CALC, DONE.
REQ-012 IDLE plus start: capture a, b and op, and go to CALC; busy=1 from the next cycle.
REQ-013 CALC: one radix-2 restoring step per cycle on operand magnitudes; exactly 32 steps, then go to DONE.
REQ-014 DONE lasts one cycle: done=1, busy=0, res valid; the next state is IDLE, or CALC if start=1 in that cycle (back-to-back accept).
REQ-015 Latency: start accepted at edge N gives done=1 in cycle N+33 for all non-special operands.
REQ-016 start while in CALC is ignored; captured operands are not disturbed.
REQ-017 Signed ops (DIV, REM) take magnitudes of a and b.
REQ-018 Signed quotient sign is a[31]^b[31]; signed remainder sign is a[31].
REQ-019 Sign correction is applied when the result is registered on entry to DONE.
REQ-020 Divide by zero (b==0): quotient 0xFFFFFFFF for both DIV and DIVU; remainder = a for both REM and REMU.
REQ-021 Signed overflow (a==0x80000000, b==0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
REQ-022 Special cases (REQ-020, REQ-021) are detected at capture; their result is forced and is not derived from the step datapath.
REQ-023 Input changes on a, b and op after capture have no effect on the result.

Reset
REQ-024 While reset is low: state=IDLE, busy=0, done=0, res=0, internal registers cleared.
REQ-025 Reset asserted mid-CALC aborts the operation; no done pulse is produced.
REQ-026 After release, the first start is accepted normally.

Configuration
REQ-027 Macro DIV_FAST_SPECIAL_EN is defined: special cases skip CALC and go directly to DONE, giving done=1 in cycle N+1.
REQ-028 Macro DIV_FAST_SPECIAL_EN is undefined: special cases still traverse all 32 CALC cycles, giving done at N+33 with the forced result of REQ-022.
REQ-029 Non-special latency is identical with and without the macro.

Structure
REQ-030 div_op_t (2-bit enum: DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU) is declared in decoder_pkg next to alu_op_t.
REQ-031 The step count constant DIV_STEPS=32 is declared in decoder_pkg.
REQ-032 word is taken from decoder_pkg.
REQ-033 Combinational sub-module div_step: inputs partial remainder, divisor and next dividend bit; outputs new remainder and quotient bit.
REQ-034 div_unit instantiates div_step once; the FSM, counter, sign handling and special-case logic stay in div_unit.

Verification
REQ-035 DIVU a=100, b=7 gives res=14 with done at N+33; REMU with the same operands gives res=2.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 gives res=0xFFFFFFFD; REM with the same operands gives res=0xFFFFFFFF.
REQ-037 Divide by zero, a=5, b=0: DIV gives 0xFFFFFFFF and REMU gives 5. Done at N+1 with DIV_FAST_SPECIAL_EN, at N+33 without.
REQ-038 Overflow: DIV a=0x80000000, b=0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
REQ-039 start pulsed at N+5 during CALC is ignored and the original result appears at N+33. Reset low at N+10 gives busy=0, done=0, res=0 and no later done pulse.
REQ-040 Back-to-back: start=1 in the DONE cycle of DIVU 100/7, with next op REMU 9/4. First res=14, then a second done 33 cycles later with res=1.
